l2_task_container_mem: RTL and testbench



---
 rtl/l2_scheduler_pkg.sv | 47 ++++
 rtl/l2_task_container_mem_sram_bank.sv | 37 +++
 rtl/l2_task_container_mem.sv | 120 ++++++++++++
 tb/tb_l2_task_container_mem.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_scheduler_pkg.sv
// Shared types for the L2 scheduler task container memory interface.
// One task container per memory word; byte strobes with a wide top lane.
package l2_scheduler_pkg;

    localparam int unsigned TASK_CONTAINER_BITS      = 294;
    localparam int unsigned TASK_CONTAINER_STRB_BITS = TASK_CONTAINER_BITS / 8;
    localparam int unsigned TC_STRB_IDX_W            = $clog2(TASK_CONTAINER_STRB_BITS);
    localparam int unsigned TC_ADDR_BITS             = 32;

    typedef logic [TASK_CONTAINER_BITS-1:0]      task_container_t;
    typedef logic [TASK_CONTAINER_STRB_BITS-1:0] task_container_strb_t;
    typedef logic [TC_ADDR_BITS-1:0]             tc_addr_t;

    typedef struct packed {
        logic                 mem_wr_en;
        task_container_strb_t mem_wstrb;
        tc_addr_t             mem_waddr;
        task_container_t      mem_wdata;
        logic                 mem_rd_en;
        tc_addr_t             mem_raddr;
    } task_container_req_t;

    typedef struct packed {
        task_container_t mem_rdata;
    } task_container_resp_t;

    typedef enum logic {
        TC_CLEAR,
        TC_READY
    } l2_tc_mem_state_e;

    // The last strobe lane also owns the residual bits above 8*STRB_W.
    function automatic task_container_t tc_strb_to_bitmask(input task_container_strb_t strb);
        task_container_t mask;
        int unsigned     lane;
        mask = '0;
        for (int unsigned b = 0; b < TASK_CONTAINER_BITS; b++) begin
            lane = b / 8;
            if (lane > TASK_CONTAINER_STRB_BITS - 1) begin
                lane = TASK_CONTAINER_STRB_BITS - 1;
            end
            mask[b] = strb[lane[TC_STRB_IDX_W-1:0]];
        end
        return mask;
    endfunction

endpackage

// File: rtl/l2_task_container_mem_sram_bank.sv
// Behavioural 1R1W bank with bit-enable writes and a registered read port.
// Same-index read/write returns the merged (write-first) word.
module l2_tc_sram_bank #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 294,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wmask_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] wr_merged;

    always_comb begin
        wr_merged = (mem_q[waddr_i] & ~wmask_i) | (wdata_i & wmask_i);
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wr_merged;
        end
        if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wr_merged : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/l2_task_container_mem.sv
// Responder end of the task container memory interface: range checking,
// strobed writes, registered reads and a zero-fill clear sequencer.
module l2_task_container_mem
    import l2_scheduler_pkg::*;
#(
    parameter int unsigned DEPTH         = 256,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  task_container_req_t  req_i,
    output task_container_resp_t resp_o,
    output logic                 rd_valid_o,
    output logic                 addr_err_o,
    output logic                 init_busy_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    l2_tc_mem_state_e state_q, state_d;
    logic [AW-1:0]    clr_cnt_q, clr_cnt_d;
    logic             rd_valid_q;
    logic             addr_err_q;
    logic             rd_zero_q;

    logic            clearing;
    logic            accept;
    logic            wr_oor;
    logic            rd_oor;
    logic            wr_go;
    logic            rd_go;
    logic            bank_we;
    logic [AW-1:0]   bank_waddr;
    task_container_t bank_wmask;
    task_container_t bank_wdata;
    task_container_t bank_rdata;

    assign clearing = (state_q == TC_CLEAR);
    assign accept   = (state_q == TC_READY) && !rst_i;
    assign wr_oor   = |req_i.mem_waddr[TC_ADDR_BITS-1:AW];
    assign rd_oor   = |req_i.mem_raddr[TC_ADDR_BITS-1:AW];
    assign wr_go    = accept && req_i.mem_wr_en && !wr_oor;
    assign rd_go    = accept && req_i.mem_rd_en && !rd_oor;

    // The sequencer owns the write port for the whole clear.
    always_comb begin
        bank_we    = wr_go;
        bank_waddr = req_i.mem_waddr[AW-1:0];
        bank_wmask = tc_strb_to_bitmask(req_i.mem_wstrb);
        bank_wdata = req_i.mem_wdata;
        if (clearing) begin
            bank_we    = 1'b1;
            bank_waddr = clr_cnt_q;
            bank_wmask = '1;
            bank_wdata = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            TC_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == AW'(DEPTH - 1)) begin
                    state_d = TC_READY;
                end
            end
            TC_READY: begin
                if (clear_i) begin
                    state_d   = TC_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d = TC_READY;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= INIT_ON_RESET ? TC_CLEAR : TC_READY;
            clr_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rd_valid_q <= accept && req_i.mem_rd_en;
            addr_err_q <= accept && ((req_i.mem_rd_en && rd_oor) || (req_i.mem_wr_en && wr_oor));
            // Out-of-range reads return zero without touching the bank's read register.
            if (accept && req_i.mem_rd_en) begin
                rd_zero_q <= rd_oor;
            end
        end
    end

    l2_tc_sram_bank #(
        .DEPTH (DEPTH),
        .WIDTH (TASK_CONTAINER_BITS)
    ) u_bank (
        .clk_i   (clk_i),
        .we_i    (bank_we),
        .waddr_i (bank_waddr),
        .wmask_i (bank_wmask),
        .wdata_i (bank_wdata),
        .re_i    (rd_go),
        .raddr_i (req_i.mem_raddr[AW-1:0]),
        .rdata_o (bank_rdata)
    );

    assign resp_o.mem_rdata = rd_zero_q ? '0 : bank_rdata;
    assign rd_valid_o       = rd_valid_q;
    assign addr_err_o       = addr_err_q;
    assign init_busy_o      = clearing;

endmodule

// File: tb/tb_l2_task_container_mem.sv
// Scoreboard bench for l2_task_container_mem: directed scenarios plus random traffic
// checked against a byte-lane array model.
module tb_l2_task_container_mem;
    import l2_scheduler_pkg::*;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned TB    = TASK_CONTAINER_BITS;
    localparam int unsigned SB    = TASK_CONTAINER_STRB_BITS;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 clear;
    task_container_req_t  req;
    task_container_resp_t resp;
    logic                 rd_valid;
    logic                 addr_err;
    logic                 busy;

    always #5 clk = ~clk;

    l2_task_container_mem #(
        .DEPTH         (DEPTH),
        .INIT_ON_RESET (1'b1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear),
        .req_i       (req),
        .resp_o      (resp),
        .rd_valid_o  (rd_valid),
        .addr_err_o  (addr_err),
        .init_busy_o (busy)
    );

    typedef struct {
        bit              has_rd;
        task_container_t rdata;
        bit              err;
    } exp_t;

    task_container_t model [DEPTH];
    exp_t            expq [$];
    int unsigned     passed = 0;
    int unsigned     total  = 0;

    task automatic check(input string name, input bit ok, input task_container_t act,
                         input task_container_t exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic bit oor(input tc_addr_t a);
        return a >= DEPTH;
    endfunction

    function automatic void model_zero();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endfunction

    // Byte lane i covers bits 8i..8i+7; the last lane stretches to the top bit.
    function automatic void model_write(input int a, input task_container_strb_t s,
                                        input task_container_t d);
        int lo, hi;
        for (int i = 0; i < SB; i++) begin
            if (s[i]) begin
                lo = 8 * i;
                hi = (i == SB - 1) ? TB - 1 : 8 * i + 7;
                for (int b = lo; b <= hi; b++) model[a][b] = d[b];
            end
        end
    endfunction

    function automatic task_container_t rand_tc();
        task_container_t d = '0;
        for (int i = 0; i < 10; i++) d = (d << 32) | task_container_t'($urandom());
        return d;
    endfunction

    task automatic issue(input bit wr, input task_container_strb_t s, input tc_addr_t wa,
                         input task_container_t wd, input bit rd, input tc_addr_t ra,
                         input bit accepted);
        exp_t e;
        @(negedge clk);
        req.mem_wr_en = wr;
        req.mem_wstrb = s;
        req.mem_waddr = wa;
        req.mem_wdata = wd;
        req.mem_rd_en = rd;
        req.mem_raddr = ra;
        if (accepted) begin
            if (wr && !oor(wa)) model_write(int'(wa), s, wd);
            e.has_rd = rd;
            e.err    = (rd && oor(ra)) || (wr && oor(wa));
            e.rdata  = (rd && !oor(ra)) ? model[int'(ra)] : '0;
            if (e.has_rd || e.err) expq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req   = '0;
            clear = 1'b0;
        end
    endtask

    task automatic count_busy(input string name, input int exp_n);
        int n = 0;
        while (busy && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, n == exp_n, task_container_t'(n), task_container_t'(exp_n));
    endtask

    task automatic check_reset_state();
        check("reset rd_valid", rd_valid == 1'b0, task_container_t'(rd_valid), '0);
        check("reset addr_err", addr_err == 1'b0, task_container_t'(addr_err), '0);
        check("reset rdata", resp.mem_rdata == '0, resp.mem_rdata, '0);
        check("reset init_busy", busy == 1'b1, task_container_t'(busy), task_container_t'(1));
    endtask

    // Monitor: every expectation is due exactly one cycle after issue.
    initial begin : monitor
        task_container_t last = '0;
        exp_t            e;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                last = '0;
            end else if (rd_valid || addr_err) begin
                if (expq.size() == 0) begin
                    check("unexpected output", 1'b0, task_container_t'({rd_valid, addr_err}), '0);
                end else begin
                    e = expq.pop_front();
                    check("rd_valid", rd_valid == e.has_rd, task_container_t'(rd_valid),
                          task_container_t'(e.has_rd));
                    check("addr_err", addr_err == e.err, task_container_t'(addr_err),
                          task_container_t'(e.err));
                    if (e.has_rd) last = e.rdata;
                    check("rdata", resp.mem_rdata == last, resp.mem_rdata, last);
                end
            end else begin
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    check("missing output", 1'b0, '0, task_container_t'({e.has_rd, e.err}));
                end
                check("rdata hold", resp.mem_rdata == last, resp.mem_rdata, last);
            end
        end
    end

    initial begin : stimulus
        task_container_t      pat_a, ones, beef;
        logic [7:0]           a5;
        task_container_strb_t all_s, top_s;
        tc_addr_t             wa, ra;
        int                   r;

        rst   = 1'b1;
        clear = 1'b0;
        req   = '0;
        a5    = 8'hA5;
        for (int i = 0; i < TB; i++) pat_a[i] = a5[i % 8];
        ones  = '1;
        beef  = '1;
        beef[15:0] = 16'hBEEF;
        all_s = '1;
        top_s = '0;
        top_s[SB-1] = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_reset_state();
        model_zero();
        @(negedge clk);
        rst = 1'b0;
        count_busy("reset clear length", 256);

        issue(0, '0, 0, '0, 1, 32'h00, 1);
        issue(0, '0, 0, '0, 1, 32'hFF, 1);
        idle(2);

        issue(1, all_s, 32'h05, pat_a, 0, 0, 1);
        issue(0, '0, 0, '0, 1, 32'h05, 1);
        idle(2);
        issue(1, task_container_strb_t'(1), 32'h05, ones, 0, 0, 1);
        issue(0, '0, 0, '0, 1, 32'h05, 1);
        issue(1, top_s, 32'h05, ones, 0, 0, 1);
        issue(0, '0, 0, '0, 1, 32'h05, 1);
        issue(1, '0, 32'h05, '0, 1, 32'h05, 1);
        idle(2);

        issue(1, task_container_strb_t'(3), 32'h10, beef, 1, 32'h10, 1);
        idle(2);

        issue(0, '0, 0, '0, 1, 32'h100, 1);
        issue(1, all_s, 32'h100, ones, 0, 0, 1);
        issue(0, '0, 0, '0, 1, 32'h00, 1);
        issue(1, all_s, 32'h200, ones, 1, 32'h300, 1);
        issue(1, all_s, 32'h07, beef, 1, 32'h10, 1);
        issue(0, '0, 0, '0, 1, 32'h07, 1);
        idle(2);

        for (int n = 0; n < 400; n++) begin
            r  = $urandom_range(0, 9);
            wa = (r == 0) ? ($urandom() | 32'h100) : tc_addr_t'($urandom_range(0, 15));
            r  = $urandom_range(0, 9);
            ra = (r == 0) ? ($urandom() | 32'h100) : tc_addr_t'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) wa = tc_addr_t'($urandom_range(0, DEPTH - 1));
            issue(1'($urandom()), task_container_strb_t'({$urandom(), $urandom()}), wa, rand_tc(),
                  1'($urandom()), ra, 1);
            if ($urandom_range(0, 9) == 0) idle(1);
        end
        idle(2);

        @(negedge clk);
        req   = '0;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_zero();
        count_busy("clear_i length", 256);
        issue(0, '0, 0, '0, 1, 32'h05, 1);
        issue(0, '0, 0, '0, 1, 32'h07, 1);
        idle(2);

        issue(1, all_s, 32'h05, pat_a, 0, 0, 1);
        @(negedge clk);
        req   = '0;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        issue(1, all_s, 32'h06, ones, 1, 32'h05, 0);
        idle(1);
        check("read in CLEAR dropped", rd_valid == 1'b0, task_container_t'(rd_valid), '0);
        repeat (96) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_zero();
        @(posedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        rst = 1'b0;
        count_busy("clear after mid-clear reset", 256);
        issue(0, '0, 0, '0, 1, 32'h05, 1);
        issue(0, '0, 0, '0, 1, 32'h06, 1);
        idle(3);

        check("scoreboard drained", expq.size() == 0, task_container_t'(expq.size()), '0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
